// File: rtl/score_display_pkg.sv
// Shared constants, FSM state type and segment decode for the score display.
package score_display_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 16;

    // Active-low cathodes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/score_display_if.sv
// Score input / display output bundle between game logic and score_display.
interface score_display_if #(
    parameter int SCORE_W = 14
);
    logic [SCORE_W-1:0] score_in;
    logic               score_valid;
    logic               busy;
    logic [6:0]         seg;
    logic               dp;
    logic [3:0]         an;

    modport master (
        output score_in, score_valid,
        input  busy, seg, dp, an
    );

    modport slave (
        input  score_in, score_valid,
        output busy, seg, dp, an
    );

endinterface

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter with a one-deep, latest-wins pending slot.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int SCORE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic [SCORE_W-1:0] i_value,
    output logic               o_busy,
    output logic               o_done,
    output logic [BCD_W-1:0]   o_bcd
);

    localparam int SH_W  = BCD_W + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    state_t             r_state, w_state_nx;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
    logic [SH_W-1:0]    r_sh, w_sh_nx;
    logic               r_pend, w_pend_nx;
    logic [SCORE_W-1:0] r_pend_val, w_pend_val_nx;
    logic [SH_W-1:0]    w_adj;
    logic [SH_W-1:0]    w_shifted;
    logic               w_last;

    always_comb begin
        w_adj = r_sh;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_sh[SCORE_W + 4*i +: 4] >= 4'd5)
                w_adj[SCORE_W + 4*i +: 4] = r_sh[SCORE_W + 4*i +: 4] + 4'd3;
        end
        w_shifted = w_adj << 1;
    end

    assign w_last = (r_state == CONV) && (r_cnt == '0);
    assign o_done = w_last;
    assign o_bcd  = w_shifted[SH_W-1 -: BCD_W];
    assign o_busy = (r_state == CONV);

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_sh_nx       = r_sh;
        w_pend_nx     = r_pend;
        w_pend_val_nx = r_pend_val;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nx = CONV;
                    w_sh_nx    = {{BCD_W{1'b0}}, i_value};
                    w_cnt_nx   = CNT_W'(SCORE_W - 1);
                end
            end
            CONV: begin
                w_sh_nx  = w_shifted;
                w_cnt_nx = r_cnt - 1'b1;
                if (i_start) begin
                    w_pend_nx     = 1'b1;
                    w_pend_val_nx = i_value;
                end
                // A strobe on the final edge is newer than any queued value, so it wins.
                if (w_last) begin
                    if (i_start || r_pend) begin
                        w_sh_nx   = {{BCD_W{1'b0}}, (i_start ? i_value : r_pend_val)};
                        w_cnt_nx  = CNT_W'(SCORE_W - 1);
                        w_pend_nx = 1'b0;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_sh       <= w_sh_nx;
            r_pend     <= w_pend_nx;
            r_pend_val <= w_pend_val_nx;
        end
    end

endmodule

// File: rtl/score_display.sv
// Score to 4-digit multiplexed seven-segment display.
// Optional macro SCORE_DISPLAY_LZ_BLANK_EN blanks leading-zero digits.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_scan,
    score_display_if.slave   bus
);

    logic [SCORE_W-1:0] w_clamped;
    logic               w_done;
    logic [BCD_W-1:0]   w_bcd;
    logic [BCD_W-1:0]   r_disp;
    logic [1:0]         r_idx;
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic [3:0]         w_nib;
    logic               w_blank;
    logic [3:0]         w_an_nx;
    logic [6:0]         w_seg_nx;

    assign w_clamped = (bus.score_in > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE)
                                                            : bus.score_in;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (bus.score_valid),
        .i_value (w_clamped),
        .o_busy  (bus.busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_disp <= '0;
        else if (w_done)
            r_disp <= w_bcd;
    end

    always_comb begin
        w_nib   = r_disp[{r_idx, 2'b00} +: 4];
        w_blank = 1'b0;
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
        w_blank = (r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == '0);
`endif
        w_an_nx  = ~(4'b0001 << r_idx);
        w_seg_nx = seg_decode(w_nib);
        if (w_blank) begin
            w_an_nx  = '1;
            w_seg_nx = SEG_BLANK;
        end
    end

    // r_idx names the slot driven on the next pulse, so the first pulse lights digit 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else if (clk_scan) begin
            r_idx <= r_idx + 2'd1;
            r_an  <= w_an_nx;
            r_seg <= w_seg_nx;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: scan expectations queued, monitor checks each scan edge.
module tb_score_display;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_scan = 1'b0;

    score_display_if #(.SCORE_W(14)) sif ();

    score_display #(
        .SCORE_W   (14),
        .MAX_SCORE (9999)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_scan (clk_scan),
        .bus      (sif.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   slot  = 0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};
    int pow10 [4] = '{1, 10, 100, 1000};

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk_exp(input int s, input int val);
        exp_t e;
        int   d;
        d      = (val / pow10[s]) % 10;
        e.an   = 4'b1111;
        e.an[s] = 1'b0;
        e.seg  = seg_tbl[d];
`ifdef SCORE_DISPLAY_LZ_BLANK_EN
        if (s > 0 && val < pow10[s]) begin
            e.an  = 4'b1111;
            e.seg = 7'h7F;
        end
`endif
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_scan(input int val);
        exp_q.push_back(mk_exp(slot, val));
        slot = (slot + 1) % 4;
        clk_scan = 1'b1;
        tick();
        clk_scan = 1'b0;
        tick();
        tick();
    endtask

    task automatic scan_all(input int val);
        for (int i = 0; i < 4; i++) pulse_scan(val);
    endtask

    task automatic run_conv(input int val, input int exp_cycles);
        int n;
        sif.score_in    = 14'(val);
        sif.score_valid = 1'b1;
        tick();
        sif.score_valid = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && sif.busy; k++) begin
            n++;
            tick();
        end
        chk("busy_len", n, exp_cycles);
    endtask

    // Monitor: every scan edge outside reset presents a new digit.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (clk_scan && !rst) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL scan_unexpected: got an=%b seg=%b, expected no scan", sif.an, sif.seg);
                end else begin
                    e = exp_q.pop_front();
                    chk("scan_an", int'(sif.an), int'(e.an));
                    chk("scan_seg", int'(sif.seg), int'(e.seg));
                    chk("scan_dp", int'(sif.dp), 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int run;
        sif.score_in    = '0;
        sif.score_valid = 1'b0;

        // 1: reset state and scan order over all-zero display, wrap on 5th pulse
        repeat (3) tick();
        chk("rst_an", int'(sif.an), 'hF);
        chk("rst_seg", int'(sif.seg), 'h7F);
        chk("rst_busy", int'(sif.busy), 0);
        chk("rst_dp", int'(sif.dp), 1);
        rst = 1'b0;
        tick();
        chk("idle_an", int'(sif.an), 'hF);
        scan_all(0);
        pulse_scan(0);

        // 2: basic conversion
        run_conv(1234, 14);
        scan_all(1234);

        // 3: clamp
        run_conv(12000, 14);
        scan_all(9999);

        // 4: back-to-back with latest-wins pending; scan during second conversion
        run = 0;
        for (int c = 0; c <= 30; c++) begin
            sif.score_valid = (c == 0 || c == 3 || c == 5);
            sif.score_in    = (c == 0) ? 14'd500 : (c == 3) ? 14'd42 : 14'd77;
            clk_scan        = (c == 16 || c == 18 || c == 20 || c == 22);
            if (clk_scan) begin
                exp_q.push_back(mk_exp(slot, 500));
                slot = (slot + 1) % 4;
            end
            tick();
            if (sif.busy && run == c) run++;
        end
        sif.score_valid = 1'b0;
        clk_scan        = 1'b0;
        chk("busy_b2b", run, 28);
        scan_all(77);

        // 5: reset mid-conversion
        sif.score_in    = 14'd1234;
        sif.score_valid = 1'b1;
        tick();
        sif.score_valid = 1'b0;
        repeat (7) tick();
        chk("mid_busy", int'(sif.busy), 1);
        rst = 1'b1;
        tick();
        chk("abort_busy", int'(sif.busy), 0);
        chk("abort_an", int'(sif.an), 'hF);
        chk("abort_seg", int'(sif.seg), 'h7F);
        rst  = 1'b0;
        slot = 0;
        repeat (20) tick();
        chk("abort_idle", int'(sif.busy), 0);
        scan_all(0);

        // 6: single digit (leading zeros lit or blanked depending on build)
        run_conv(7, 14);
        scan_all(7);

        repeat (5) tick();
        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
